apu_dma_controller: RTL and testbench

- Sequences all DMA traffic on the CPU bus: sprite (OAM) DMA triggered by writes to $4014, and the DMC sample fetches requested by the APU over its dma_req/dma_ack/dma_address handshake.
- Halts the CPU through RDY, drives the bus address, direction and write data while it owns the bus, and arbitrates between the two DMA sources on get/put cycle parity.
- Sits between the CPU core, the APU and the bus address/data muxes in the CPU top level.

---
 rtl/apu_pkg.sv | 33 +++
 rtl/apu_dma_controller.sv | 133 +++++++++++++
 tb/tb_apu_dma_controller.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
// Shared types and constants for the APU DMA controller.
// The dispatch helper encodes the DMC-over-OAM priority used at every GET slot.
package apu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        OAM_GET,
        OAM_PUT,
        DMC_GET
    } dma_state_t;

    typedef enum logic {
        GET,
        PUT
    } parity_t;

    localparam logic [15:0] DEF_OAM_DATA_ADDR    = 16'h2004;
    localparam logic [15:0] DEF_OAM_TRIGGER_ADDR = 16'h4014;

    // Decision taken when the following CPU cycle is a GET slot.
    function automatic dma_state_t dispatch(input logic dmc_req, input logic oam_pending);
        if (dmc_req) begin
            return DMC_GET;
        end
        if (oam_pending) begin
            return OAM_GET;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/apu_dma_controller.sv
// CPU-bus DMA sequencer: OAM sprite DMA ($4014) and APU DMC sample fetches,
// arbitrated on GET/PUT cycle parity while the CPU is held through RDY.
module apu_dma_controller
    import apu_pkg::*;
#(
    parameter logic [15:0] OAM_DATA_ADDR    = DEF_OAM_DATA_ADDR,
    parameter logic [15:0] OAM_TRIGGER_ADDR = DEF_OAM_TRIGGER_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_clk,
    input  logic [15:0] cpu_a,
    input  logic        cpu_r_nw,
    input  logic [7:0]  cpu_dout,
    input  logic [7:0]  mem_din,
    input  logic        dmc_req,
    input  logic [14:0] dmc_addr,
    output logic        dmc_ack,
    output logic        cpu_rdy,
    output logic        dma_own,
    output logic [15:0] bus_a,
    output logic        bus_r_nw,
    output logic [7:0]  bus_dout
);

    dma_state_t  state_q, state_d;
    parity_t     parity_q;
    logic        oam_pending_q, oam_pending_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;
    logic [15:0] cpu_a_q, cpu_a_d;
    logic        trigger;

    assign trigger  = !cpu_r_nw && (cpu_a == OAM_TRIGGER_ADDR);
    assign bus_dout = latch_q;

    always_comb begin
        state_d       = state_q;
        oam_pending_d = oam_pending_q;
        page_d        = page_q;
        idx_d         = idx_q;
        latch_d       = latch_q;
        cpu_a_d       = cpu_a_q;
        cpu_rdy       = 1'b1;
        dma_own       = 1'b0;
        dmc_ack       = 1'b0;
        bus_a         = '0;
        bus_r_nw      = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (oam_pending_q || dmc_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                cpu_rdy = 1'b0;
                // The CPU only stops on a read; that read doubles as the first alignment slot.
                if (cpu_r_nw) begin
                    cpu_a_d = cpu_a;
                    state_d = (parity_q == PUT) ? dispatch(dmc_req, oam_pending_q) : ALIGN;
                end
            end
            ALIGN: begin
                cpu_rdy = 1'b0;
                dma_own = 1'b1;
                bus_a   = cpu_a_q;
                if (parity_q == PUT) begin
                    state_d = dispatch(dmc_req, oam_pending_q);
                end
            end
            DMC_GET: begin
                cpu_rdy = 1'b0;
                dma_own = 1'b1;
                dmc_ack = 1'b1;
                bus_a   = {1'b1, dmc_addr};
                state_d = ALIGN;
            end
            OAM_GET: begin
                cpu_rdy = 1'b0;
                dma_own = 1'b1;
                bus_a   = {page_q, idx_q};
                latch_d = mem_din;
                state_d = OAM_PUT;
            end
            OAM_PUT: begin
                cpu_rdy  = 1'b0;
                dma_own  = 1'b1;
                bus_a    = OAM_DATA_ADDR;
                bus_r_nw = 1'b0;
                if (idx_q == 8'hFF) begin
                    idx_d         = 8'h00;
                    oam_pending_d = 1'b0;
                    state_d       = dispatch(dmc_req, 1'b0);
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = dispatch(dmc_req, 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A trigger landing on the final PUT must win over the pending clear.
        if (trigger) begin
            page_d        = cpu_dout;
            oam_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            parity_q      <= GET;
            oam_pending_q <= 1'b0;
            page_q        <= 8'h00;
            idx_q         <= 8'h00;
            latch_q       <= 8'h00;
            cpu_a_q       <= 16'h0000;
        end else if (cpu_clk) begin
            state_q       <= state_d;
            parity_q      <= (parity_q == GET) ? PUT : GET;
            oam_pending_q <= oam_pending_d;
            page_q        <= page_d;
            idx_q         <= idx_d;
            latch_q       <= latch_d;
            cpu_a_q       <= cpu_a_d;
        end
    end

endmodule

// File: tb/tb_apu_dma_controller.sv
// Self-checking bench for apu_dma_controller: directed OAM/DMC scenarios plus
// randomized transfers scored against cycle-count and byte-order rules.
module tb_apu_dma_controller;
    import apu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_clk = 1'b0;
    logic [15:0] cpu_a = 16'h8123;
    logic        cpu_r_nw = 1'b1;
    logic [7:0]  cpu_dout = 8'h00;
    logic [7:0]  mem_din;
    logic        dmc_req = 1'b0;
    logic [14:0] dmc_addr = 15'h0000;
    logic        dmc_ack;
    logic        cpu_rdy;
    logic        dma_own;
    logic [15:0] bus_a;
    logic        bus_r_nw;
    logic [7:0]  bus_dout;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    localparam logic [15:0] CpuIdleAddr = 16'h8123;

    apu_dma_controller dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_clk  (cpu_clk),
        .cpu_a    (cpu_a),
        .cpu_r_nw (cpu_r_nw),
        .cpu_dout (cpu_dout),
        .mem_din  (mem_din),
        .dmc_req  (dmc_req),
        .dmc_addr (dmc_addr),
        .dmc_ack  (dmc_ack),
        .cpu_rdy  (cpu_rdy),
        .dma_own  (dma_own),
        .bus_a    (bus_a),
        .bus_r_nw (bus_r_nw),
        .bus_dout (bus_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_of(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    assign mem_din = mem_of(dma_own ? bus_a : cpu_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU cycle: cpu_clk is high for exactly one posedge.
    task automatic step();
        @(negedge clk) cpu_clk = 1'b1;
        @(negedge clk) cpu_clk = 1'b0;
        cyc++;
    endtask

    task automatic idle(input int n);
        cpu_r_nw = 1'b1;
        cpu_a    = CpuIdleAddr;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_rdy", cpu_rdy, 1'b1);
            step();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy"}, cpu_rdy, 1'b1);
        chk({tag, "_own"}, dma_own, 1'b0);
        chk({tag, "_ack"}, dmc_ack, 1'b0);
        chk({tag, "_bus_a"}, bus_a, 16'h0000);
        chk({tag, "_r_nw"}, bus_r_nw, 1'b1);
        chk({tag, "_dout"}, bus_dout, 8'h00);
    endtask

    task automatic release_reset();
        @(negedge clk) rst = 1'b1;
        cyc = 0;
    endtask

    // OAM transfer; steal>0 raises dmc_req right after put number 'steal',
    // abort>=0 asserts reset while the put of byte 'abort' is on the bus.
    task automatic run_oam(input logic [7:0] page, input int nwr, input int steal,
                           input int abort);
        int  halt_cnt = 0;
        int  gets = 0;
        int  puts = 0;
        int  errs = 0;
        int  acks = 0;
        int  wr_left = nwr;
        int  first_read = -1;
        int  exp_len;
        bit  done = 1'b0;
        bit  aborted = 1'b0;
        bit  armed = 1'b0;
        bit  ack_now;
        bit  put_now;

        dmc_addr = 15'($urandom_range(0, 32767));
        cpu_a    = 16'h4014;
        cpu_r_nw = 1'b0;
        cpu_dout = page;
        #1;
        chk("trig_rdy", cpu_rdy, 1'b1);
        step();
        for (int n = 0; n < 1200; n++) begin
            #1;
            if (halt_cnt > 0 && cpu_rdy) begin
                done = 1'b1;
                break;
            end
            ack_now = 1'b0;
            put_now = 1'b0;
            if (!cpu_rdy && first_read < 0 && wr_left > 0) begin
                cpu_r_nw = 1'b0;
                cpu_a    = 16'h0300;
                cpu_dout = 8'h11;
                wr_left--;
            end else begin
                cpu_r_nw = 1'b1;
                cpu_a    = CpuIdleAddr;
            end
            #1;
            if (!cpu_rdy) begin
                halt_cnt++;
                if (first_read < 0 && cpu_r_nw) first_read = cyc;
            end
            if (dmc_ack) begin
                acks++;
                ack_now = 1'b1;
                if (bus_a !== {1'b1, dmc_addr} || bus_r_nw !== 1'b1 ||
                    mem_din !== mem_of({1'b1, dmc_addr})) errs++;
            end else if (dma_own && !bus_r_nw) begin
                if (bus_a !== 16'h2004 || bus_dout !== mem_of({page, puts[7:0]})) errs++;
                puts++;
                put_now = 1'b1;
            end else if (dma_own && bus_a[15:8] == page) begin
                if (bus_a[7:0] !== gets[7:0] || gets != puts) errs++;
                gets++;
            end else if (dma_own && bus_a !== CpuIdleAddr) begin
                errs++;
            end
            if (abort >= 0 && put_now && puts == abort + 1) begin
                aborted = 1'b1;
                break;
            end
            if (steal > 0 && put_now && puts == steal && !armed) begin
                dmc_req = 1'b1;
                armed   = 1'b1;
            end
            step();
            if (ack_now) dmc_req = 1'b0;
        end

        if (aborted) begin
            #2 rst = 1'b0;
            #1;
            chk_reset_outputs("abort_rst");
            release_reset();
            cpu_r_nw = 1'b1;
            cpu_a    = CpuIdleAddr;
            #1;
            chk("abort_idle_rdy", cpu_rdy, 1'b1);
            step();
            #1;
            chk("abort_no_resume_rdy", cpu_rdy, 1'b1);
            chk("abort_no_resume_own", dma_own, 1'b0);
            step();
            #1;
            chk("abort_still_idle", cpu_rdy, 1'b1);
            return;
        end

        exp_len = 513 + ((first_read % 2 == 0) ? 1 : 0) + nwr + ((steal > 0) ? 2 : 0);
        chk("oam_done", done, 1'b1);
        chk("oam_halt_len", halt_cnt, exp_len);
        chk("oam_gets", gets, 256);
        chk("oam_puts", puts, 256);
        chk("oam_order_errs", errs, 0);
        chk("oam_dmc_acks", acks, (steal > 0) ? 1 : 0);
        chk("oam_release_own", dma_own, 1'b0);
        dmc_req = 1'b0;
    endtask

    // DMC fetch with the CPU reading; cancel drops the request during HALT.
    task automatic run_dmc(input logic [14:0] addr, input bit cancel);
        int  halt_cnt = 0;
        int  acks = 0;
        int  errs = 0;
        int  first_read = -1;
        int  exp_len;
        bit  done = 1'b0;
        bit  dropped = 1'b0;
        bit  ack_now;

        cpu_a    = CpuIdleAddr;
        cpu_r_nw = 1'b1;
        dmc_addr = addr;
        dmc_req  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (halt_cnt > 0 && cpu_rdy) begin
                done = 1'b1;
                break;
            end
            ack_now  = 1'b0;
            cpu_r_nw = 1'b1;
            cpu_a    = CpuIdleAddr;
            if (cancel && !cpu_rdy && !dropped) begin
                cpu_r_nw = 1'b0;
                cpu_a    = 16'h0300;
                dmc_req  = 1'b0;
                dropped  = 1'b1;
            end
            #1;
            if (!cpu_rdy) begin
                halt_cnt++;
                if (first_read < 0 && cpu_r_nw) first_read = cyc;
            end
            if (dmc_ack) begin
                acks++;
                ack_now = 1'b1;
                if (bus_a !== {1'b1, addr} || bus_r_nw !== 1'b1 || dma_own !== 1'b1 ||
                    mem_din !== mem_of({1'b1, addr})) errs++;
            end
            step();
            if (ack_now) dmc_req = 1'b0;
        end
        if (cancel) exp_len = 1 + ((first_read % 2 == 0) ? 2 : 1);
        else        exp_len = (first_read % 2 == 0) ? 4 : 3;
        chk("dmc_done", done, 1'b1);
        chk("dmc_acks", acks, cancel ? 0 : 1);
        chk("dmc_bus_errs", errs, 0);
        chk("dmc_halt_len", halt_cnt, exp_len);
        chk("dmc_release_own", dma_own, 1'b0);
        dmc_req = 1'b0;
    endtask

    initial begin
        int page;
        int nwr;
        int steal;

        #3;
        chk_reset_outputs("por");
        release_reset();
        idle(3);

        // OAM from page 2, both halt parities, no CPU writes.
        run_oam(8'h02, 0, -1, -1);
        idle(1);
        run_oam(8'h02, 0, -1, -1);
        idle(2);

        // Two CPU write cycles keep the controller in HALT.
        run_oam(8'h03, 2, -1, -1);
        idle(1);

        // DMC fetch from $C000 on both parities.
        run_dmc(15'h4000, 1'b0);
        idle(1);
        run_dmc(15'h4000, 1'b0);
        idle(2);

        // DMC steal while OAM is at byte $10.
        run_oam(8'h04, 0, 16, -1);
        idle(2);

        // DMC request dropped during HALT.
        run_dmc(15'h1234, 1'b1);
        idle(1);
        run_dmc(15'h1234, 1'b1);
        idle(2);

        // Reset in the middle of OAM at byte $40.
        run_oam(8'h05, 0, -1, 8'h40);
        idle(2);

        for (int t = 0; t < 4; t++) begin
            page  = int'($urandom_range(0, 127));
            nwr   = int'($urandom_range(0, 2));
            steal = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 256)) : -1;
            run_oam(8'(page), nwr, steal, -1);
            idle(int'($urandom_range(0, 3)));
            run_dmc(15'($urandom_range(0, 32767)), 1'($urandom_range(0, 1)));
            idle(int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
